// File: rtl/agc_stim_sequencer_pkg.sv
// Shared definitions for the AGC stimulus sequencer: FSM state encoding and
// the bit layout of one program entry {delay, mask, value, pulse, last}.
package agc_stim_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int LAST_BIT  = 0;
    localparam int PULSE_BIT = 1;
    localparam int VALUE_LSB = 2;

    function automatic int mask_lsb(input int num_ch);
        return VALUE_LSB + num_ch;
    endfunction

    function automatic int delay_lsb(input int num_ch);
        return VALUE_LSB + 2 * num_ch;
    endfunction

    function automatic int entry_w(input int delay_w, input int num_ch);
        return delay_w + 2 * num_ch + 2;
    endfunction

endpackage

// File: rtl/agc_stim_sequencer_if.sv
// Control, programming and stimulus-output bundle of the sequencer.
// The bench side is the master, the sequencer is the slave.
interface agc_stim_sequencer_if #(
    parameter int NUM_CH  = 16,
    parameter int DEPTH   = 16,
    parameter int DELAY_W = 16
);
    logic                       start;
    logic                       pause;
    logic                       prog_we;
    logic [$clog2(DEPTH)-1:0]   prog_addr;
    logic [DELAY_W-1:0]         prog_delay;
    logic [NUM_CH-1:0]          prog_mask;
    logic [NUM_CH-1:0]          prog_value;
    logic                       prog_pulse;
    logic                       prog_last;
    logic [NUM_CH-1:0]          stim_out;
    logic                       busy;
    logic                       done;
    logic                       step_strobe;
    logic [$clog2(DEPTH)-1:0]   step_idx;

    modport master (
        output start, pause, prog_we, prog_addr, prog_delay, prog_mask,
               prog_value, prog_pulse, prog_last,
        input  stim_out, busy, done, step_strobe, step_idx
    );

    modport slave (
        input  start, pause, prog_we, prog_addr, prog_delay, prog_mask,
               prog_value, prog_pulse, prog_last,
        output stim_out, busy, done, step_strobe, step_idx
    );
endinterface

// File: rtl/agc_stim_sequencer_mem.sv
// Program store: DEPTH x WIDTH register file, one write port, one async read port.
// Contents survive reset so a bench can re-run the same script after an abort.
module agc_stim_sequencer_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 50
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (we_i && waddr_i == AW'(gi)) begin
                mem_q[gi] <= wdata_i;
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/agc_stim_sequencer.sv
// Scripted stimulus driver: walks a program of timed mask/value steps and
// drives NUM_CH lines cycle-accurately, with optional one-cycle pulse steps.
module agc_stim_sequencer
    import agc_stim_sequencer_pkg::*;
#(
    parameter int                NUM_CH      = 16,
    parameter int                DEPTH       = 16,
    parameter int                DELAY_W     = 16,
    parameter logic [NUM_CH-1:0] RESET_VALUE = '1
) (
    input  logic                CLOCK,
    input  logic                SIM_RST,
    agc_stim_sequencer_if.slave bus
);
    localparam int            AW        = $clog2(DEPTH);
    localparam int            EW        = entry_w(DELAY_W, NUM_CH);
    localparam int            MASK_LSB  = mask_lsb(NUM_CH);
    localparam int            DELAY_LSB = delay_lsb(NUM_CH);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [DELAY_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [AW-1:0]       step_idx_q, step_idx_d;
    logic                loaded_q, loaded_d;
    logic [NUM_CH-1:0]   stim_q, stim_d;
    logic [NUM_CH-1:0]   pmask_q, pmask_d;
    logic [NUM_CH-1:0]   pbits_q, pbits_d;
    logic                pend_q, pend_d;
    logic                done_q, done_d;
    logic                strobe_q, strobe_d;

    logic                wr_en;
    logic [EW-1:0]       wr_data;
    logic [EW-1:0]       rd_entry;
    logic [DELAY_W-1:0]  e_delay;
    logic [NUM_CH-1:0]   e_mask;
    logic [NUM_CH-1:0]   e_value;
    logic                e_pulse;
    logic                e_last;
    logic [NUM_CH-1:0]   base;
    logic [DELAY_W-1:0]  eff_cnt;

    assign wr_en   = bus.prog_we && (state_q != S_RUN);
    assign wr_data = {bus.prog_delay, bus.prog_mask, bus.prog_value,
                      bus.prog_pulse, bus.prog_last};

    agc_stim_sequencer_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk     (CLOCK),
        .we_i    (wr_en),
        .waddr_i (bus.prog_addr),
        .wdata_i (wr_data),
        .raddr_i (idx_q),
        .rdata_o (rd_entry)
    );

    assign e_delay = rd_entry[DELAY_LSB +: DELAY_W];
    assign e_mask  = rd_entry[MASK_LSB +: NUM_CH];
    assign e_value = rd_entry[VALUE_LSB +: NUM_CH];
    assign e_pulse = rd_entry[PULSE_BIT];
    assign e_last  = rd_entry[LAST_BIT];

    // Each step's delay is fetched on the first RUN edge of that step (loaded_q=0),
    // so a write coinciding with start is already visible when entry 0 is read.
    // Fetching d and loading d-1 keeps the apply edge at step start + d + 1.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        loaded_d   = loaded_q;
        done_d     = done_q;
        step_idx_d = step_idx_q;
        pmask_d    = pmask_q;
        pbits_d    = pbits_q;
        pend_d     = 1'b0;
        strobe_d   = 1'b0;
        base       = pend_q ? ((stim_q & ~pmask_q) | (pbits_q & pmask_q)) : stim_q;
        stim_d     = base;
        eff_cnt    = loaded_q ? cnt_q : e_delay;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d  = S_RUN;
                    idx_d    = '0;
                    loaded_d = 1'b0;
                    done_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (!bus.pause) begin
                    if (eff_cnt != '0) begin
                        cnt_d    = eff_cnt - DELAY_W'(1);
                        loaded_d = 1'b1;
                    end else begin
                        stim_d     = (base & ~e_mask) | (e_value & e_mask);
                        strobe_d   = 1'b1;
                        step_idx_d = idx_q;
                        loaded_d   = 1'b0;
                        pend_d     = e_pulse;
                        pmask_d    = e_mask;
                        pbits_d    = base & e_mask;
                        if (e_last || idx_q == LAST_IDX) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + AW'(1);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (SIM_RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            step_idx_q <= '0;
            loaded_q   <= 1'b0;
            stim_q     <= RESET_VALUE;
            pmask_q    <= '0;
            pbits_q    <= '0;
            pend_q     <= 1'b0;
            done_q     <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            step_idx_q <= step_idx_d;
            loaded_q   <= loaded_d;
            stim_q     <= stim_d;
            pmask_q    <= pmask_d;
            pbits_q    <= pbits_d;
            pend_q     <= pend_d;
            done_q     <= done_d;
            strobe_q   <= strobe_d;
        end
    end

    assign bus.stim_out    = stim_q;
    assign bus.busy        = (state_q == S_RUN);
    assign bus.done        = done_q;
    assign bus.step_strobe = strobe_q;
    assign bus.step_idx    = step_idx_q;

endmodule
